// File: rtl/conv_window_feeder16_pkg.sv
// Shared types and helpers for the float16 conv window feeder.
// State encoding, window geometry functions and float16 constants.
package conv16_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STREAM,
      ST_GAP,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int          WGT_AW    = 7;
   localparam logic [15:0] FP16_ZERO = 16'h0000;
   localparam logic [15:0] FP16_ONE  = 16'h3C00;

   function automatic int taps(input int kr, input int kc);
      return kr * kc;
   endfunction

   function automatic int out_dim(input int img, input int k);
      return img - k + 1;
   endfunction

endpackage

// File: rtl/conv_window_feeder16_if.sv
// Operand/result bus between the window feeder, its RAMs and the PE.
// master = feeder side, slave = RAM/PE side.
interface conv_window_feeder16_if
   import conv16_pkg::*;
#(
   parameter int data_width = 16,
   parameter int addr_width = 10
);

   logic [addr_width-1:0] fmap_addr;
   logic [data_width-1:0] fmap_rdata;
   logic [WGT_AW-1:0]     wgt_addr;
   logic [data_width-1:0] wgt_rdata;
   logic [data_width-1:0] pe_floatA;
   logic [data_width-1:0] pe_floatB;
   logic                  pe_conv_en;
   logic [data_width-1:0] pe_result;
   logic                  pe_out_valid;
   logic                  res_wen;
   logic [addr_width-1:0] res_waddr;
   logic [data_width-1:0] res_wdata;

   modport master (
      output fmap_addr,
      input  fmap_rdata,
      output wgt_addr,
      input  wgt_rdata,
      output pe_floatA,
      output pe_floatB,
      output pe_conv_en,
      input  pe_result,
      input  pe_out_valid,
      output res_wen,
      output res_waddr,
      output res_wdata
   );

   modport slave (
      input  fmap_addr,
      output fmap_rdata,
      input  wgt_addr,
      output wgt_rdata,
      input  pe_floatA,
      input  pe_floatB,
      input  pe_conv_en,
      output pe_result,
      output pe_out_valid,
      input  res_wen,
      input  res_waddr,
      input  res_wdata
   );

endinterface

// File: rtl/conv_window_feeder16_addr_gen.sv
// Window/tap counters and fmap/weight address math.
// Stepped by the feeder FSM; held at zero while clear is high.
module conv_addr_gen16
   import conv16_pkg::*;
#(
   parameter int weight_length = 3,
   parameter int weight_width  = 3,
   parameter int img_w         = 28,
   parameter int img_h         = 28,
   parameter int addr_width    = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  tap_step,
   input  logic                  win_step,
   output logic [addr_width-1:0] fmap_addr,
   output logic [WGT_AW-1:0]     wgt_addr,
   output logic                  last_tap,
   output logic                  last_win
);

   localparam int OUT_W = out_dim(img_w, weight_width);
   localparam int OUT_H = out_dim(img_h, weight_length);

   localparam logic [WGT_AW-1:0]     KC_M  = WGT_AW'(weight_width - 1);
   localparam logic [WGT_AW-1:0]     KR_M  = WGT_AW'(weight_length - 1);
   localparam logic [WGT_AW-1:0]     KC_A  = WGT_AW'(weight_width);
   localparam logic [addr_width-1:0] COL_M = addr_width'(OUT_W - 1);
   localparam logic [addr_width-1:0] ROW_M = addr_width'(OUT_H - 1);
   localparam logic [addr_width-1:0] IMG_W = addr_width'(img_w);

   logic [WGT_AW-1:0]     kc;
   logic [WGT_AW-1:0]     kr;
   logic [addr_width-1:0] col;
   logic [addr_width-1:0] row;
   logic [addr_width-1:0] pix_row;
   logic [addr_width-1:0] pix_col;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kc  <= '0;
         kr  <= '0;
         col <= '0;
         row <= '0;
      end else if (clear) begin
         kc  <= '0;
         kr  <= '0;
         col <= '0;
         row <= '0;
      end else begin
         if (tap_step) begin
            if (kc == KC_M) begin
               kc <= '0;
               kr <= (kr == KR_M) ? '0 : kr + WGT_AW'(1);
            end else begin
               kc <= kc + WGT_AW'(1);
            end
         end
         if (win_step) begin
            if (col == COL_M) begin
               col <= '0;
               row <= (row == ROW_M) ? '0 : row + addr_width'(1);
            end else begin
               col <= col + addr_width'(1);
            end
         end
      end
   end

   always_comb begin
      pix_row   = row + addr_width'(kr);
      pix_col   = col + addr_width'(kc);
      fmap_addr = pix_row * IMG_W + pix_col;
      wgt_addr  = kr * KC_A + kc;
      last_tap  = (kc == KC_M) && (kr == KR_M);
      last_win  = (col == COL_M) && (row == ROW_M);
   end

endmodule

// File: rtl/conv_window_feeder16.sv
// Feeds KxK windows of a float16 feature map into the PE, one tap per clk,
// and writes each PE result to the output map.
module conv_window_feeder16
   import conv16_pkg::*;
#(
   parameter int data_width    = 16,
   parameter int weight_length = 3,
   parameter int weight_width  = 3,
   parameter int img_w         = 28,
   parameter int img_h         = 28,
   parameter int addr_width    = 10
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   conv_window_feeder16_if.master    bus
);

   localparam int OUT_W = out_dim(img_w, weight_width);
   localparam int OUT_H = out_dim(img_h, weight_length);

   localparam logic [addr_width-1:0] N_WIN = addr_width'(OUT_W * OUT_H);

   state_t state;
   state_t state_nx;

   logic                  tap_step;
   logic                  win_step;
   logic                  clear;
   logic                  issue_v;
   logic                  capture;
   logic                  last_tap;
   logic                  last_win;
   logic                  conv_en_q;
   logic                  res_wen_q;
   logic [addr_width-1:0] res_waddr_q;
   logic [data_width-1:0] res_wdata_q;
   logic [addr_width-1:0] res_cnt;

   conv_addr_gen16 #(
      .weight_length (weight_length),
      .weight_width  (weight_width),
      .img_w         (img_w),
      .img_h         (img_h),
      .addr_width    (addr_width)
   ) u_addr_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .tap_step  (tap_step),
      .win_step  (win_step),
      .fmap_addr (bus.fmap_addr),
      .wgt_addr  (bus.wgt_addr),
      .last_tap  (last_tap),
      .last_win  (last_win)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (start) state_nx = ST_STREAM;
         ST_STREAM: if (last_tap) state_nx = ST_GAP;
         ST_GAP:    state_nx = last_win ? ST_DRAIN : ST_STREAM;
         ST_DRAIN:  if (res_cnt == N_WIN) state_nx = ST_DONE;
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Results are only taken while a run is in flight.
   always_comb begin
      issue_v  = 1'b0;
      win_step = 1'b0;
      clear    = 1'b0;
      capture  = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            clear = 1'b1;
            busy  = 1'b0;
         end
         ST_STREAM: begin
            issue_v = 1'b1;
            capture = bus.pe_out_valid;
         end
         ST_GAP: begin
            win_step = 1'b1;
            capture  = bus.pe_out_valid;
         end
         ST_DRAIN: capture = bus.pe_out_valid;
         ST_DONE:  done = 1'b1;
         default:  busy = 1'b0;
      endcase
      tap_step = issue_v;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conv_en_q   <= 1'b0;
         res_wen_q   <= 1'b0;
         res_waddr_q <= '0;
         res_wdata_q <= '0;
         res_cnt     <= '0;
      end else begin
         conv_en_q <= issue_v;
         res_wen_q <= capture;
         if (clear) begin
            res_cnt <= '0;
         end else if (capture) begin
            res_waddr_q <= res_cnt;
            res_wdata_q <= bus.pe_result;
            res_cnt     <= res_cnt + addr_width'(1);
         end
      end
   end

   assign bus.pe_floatA  = bus.fmap_rdata;
   assign bus.pe_floatB  = bus.wgt_rdata;
   assign bus.pe_conv_en = conv_en_q;
   assign bus.res_wen    = res_wen_q;
   assign bus.res_waddr  = res_waddr_q;
   assign bus.res_wdata  = res_wdata_q;

endmodule

// File: tb/tb_conv_window_feeder16.sv
// Randomized bench for conv_window_feeder16 on a 5x4 map with a 3x3 kernel.
// RAMs and PE are behavioural; expected results come from direct window sums.
module tb_conv_window_feeder16;
   import conv16_pkg::*;

   localparam int KR     = 3;
   localparam int KC     = 3;
   localparam int K      = KR * KC;
   localparam int IW     = 5;
   localparam int IH     = 4;
   localparam int OW     = IW - KC + 1;
   localparam int OH     = IH - KR + 1;
   localparam int N      = OW * OH;
   localparam int P      = K + 1;
   localparam int DONE_T = N * P + 3;
   localparam int AW     = 10;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic start   = 1'b0;
   logic busy;
   logic done;

   conv_window_feeder16_if #(.data_width(16), .addr_width(AW)) bus();

   conv_window_feeder16 #(
      .data_width    (16),
      .weight_length (KR),
      .weight_width  (KC),
      .img_w         (IW),
      .img_h         (IH),
      .addr_width    (AW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] fmap_mem [1024];
   logic [15:0] wgt_mem  [128];
   logic [15:0] exp_res  [N];
   int          acc;
   int          cnt;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [15:0] i2h(input int v);
      int e;
      int m;
      if (v <= 0) return 16'h0000;
      e = 0;
      while ((v >> (e + 1)) != 0) e++;
      if (e <= 10) m = (v << (10 - e)) & 'h3FF;
      else         m = (v >> (e - 10)) & 'h3FF;
      return {1'b0, 5'(e + 15), 10'(m)};
   endfunction

   function automatic int h2i(input logic [15:0] h);
      int e;
      int m;
      if (h[14:10] == 5'd0) return 0;
      m = 1024 + int'(h[9:0]);
      e = int'(h[14:10]) - 15;
      if (e < 0) return 0;
      if (e >= 10) return m << (e - 10);
      return m >> (10 - e);
   endfunction

   always @(posedge clk) begin
      bus.fmap_rdata <= fmap_mem[bus.fmap_addr];
      bus.wgt_rdata  <= wgt_mem[bus.wgt_addr];
   end

   // PE: accumulates while enabled, reports on the first low cycle.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc              <= 0;
         cnt              <= 0;
         bus.pe_out_valid <= 1'b0;
         bus.pe_result    <= 16'h0000;
      end else begin
         bus.pe_out_valid <= 1'b0;
         if (bus.pe_conv_en) begin
            acc <= acc + h2i(bus.pe_floatA) * h2i(bus.pe_floatB);
            cnt <= cnt + 1;
         end else begin
            if (cnt == K) begin
               bus.pe_out_valid <= 1'b1;
               bus.pe_result    <= i2h(acc);
            end
            acc <= 0;
            cnt <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // mode 0: all ones, 1: pixel=index with one-hot centre weight, 2: random
   task automatic fill(input int mode);
      int s;
      for (int i = 0; i < 1024; i++) begin
         case (mode)
            0:       fmap_mem[i] = FP16_ONE;
            1:       fmap_mem[i] = i2h(i);
            default: fmap_mem[i] = i2h(int'($urandom_range(0, 15)));
         endcase
      end
      for (int j = 0; j < 128; j++) begin
         case (mode)
            0:       wgt_mem[j] = FP16_ONE;
            1:       wgt_mem[j] = (j == 4) ? FP16_ONE : FP16_ZERO;
            default: wgt_mem[j] = i2h(int'($urandom_range(0, 3)));
         endcase
      end
      for (int w = 0; w < N; w++) begin
         s = 0;
         for (int p = 0; p < K; p++)
            s += h2i(fmap_mem[(w / OW + p / KC) * IW + w % OW + p % KC])
                 * h2i(wgt_mem[p]);
         exp_res[w] = i2h(s);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " done"}, 32'(done), 0);
      chk({tag, " en"}, 32'(bus.pe_conv_en), 0);
      chk({tag, " wen"}, 32'(bus.res_wen), 0);
      chk({tag, " faddr"}, 32'(bus.fmap_addr), 0);
      chk({tag, " waddr_w"}, 32'(bus.wgt_addr), 0);
      chk({tag, " res_waddr"}, 32'(bus.res_waddr), 0);
      chk({tag, " res_wdata"}, 32'(bus.res_wdata), 0);
   endtask

   task automatic run(input int abort_t, input bit poke);
      int  w;
      int  p;
      int  rw;
      bit  exp_en;
      bit  exp_wen;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t <= DONE_T + 2; t++) begin
         w = t / P;
         p = t % P;
         if (t < N * P && p < K) begin
            chk($sformatf("fmap_addr t%0d", t), 32'(bus.fmap_addr),
                (w / OW + p / KC) * IW + w % OW + p % KC);
            chk($sformatf("wgt_addr t%0d", t), 32'(bus.wgt_addr), p);
         end
         exp_en = (t >= 1) && (t - 1 < N * P) && ((t - 1) % P < K);
         chk($sformatf("conv_en t%0d", t), 32'(bus.pe_conv_en), 32'(exp_en));
         rw = t - K - 3;
         exp_wen = (rw >= 0) && (rw % P == 0) && (rw / P < N);
         chk($sformatf("res_wen t%0d", t), 32'(bus.res_wen), 32'(exp_wen));
         if (exp_wen) begin
            chk($sformatf("res_waddr t%0d", t), 32'(bus.res_waddr), rw / P);
            chk($sformatf("res_wdata t%0d", t), 32'(bus.res_wdata),
                32'(exp_res[rw / P]));
         end
         chk($sformatf("busy t%0d", t), 32'(busy), 32'(t <= DONE_T));
         chk($sformatf("done t%0d", t), 32'(done), 32'(t == DONE_T));
         if (t == abort_t) begin
            reset_n = 1'b0;
            #1;
            check_zero("abort");
            @(negedge clk);
            check_zero("abort_hold");
            reset_n = 1'b1;
            return;
         end
         start = poke && (t == 13 || t == DONE_T);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      fill(0);
      @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;
      run(-1, 1'b0);
      fill(1);
      run(-1, 1'b0);
      fill(2);
      run(-1, 1'b1);
      fill(2);
      run(-1, 1'b0);
      fill(0);
      run(2 * P + 4, 1'b0);
      run(-1, 1'b0);
      fill(2);
      run(-1, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
